// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the bit-serial ALU sequencer:
//             3-bit opcode encodings, sequencer state enum, default width
//             and a small opcode classification helper.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [2:0] OP_AND      = 3'b000;
    localparam logic [2:0] OP_NOT      = 3'b001;
    localparam logic [2:0] OP_OR       = 3'b010;
    localparam logic [2:0] OP_XOR      = 3'b011;
    localparam logic [2:0] OP_ADD      = 3'b100;
    localparam logic [2:0] OP_SUB      = 3'b101;
    localparam logic [2:0] OP_TRANSFER = 3'b110;
    localparam logic [2:0] OP_TEST     = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ADD and SUB are the only opcodes whose carry chain is meaningful.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bit_slice
//  Purpose  : Combinational 1-bit ALU slice. ADD uses a full adder; the
//             logic ops and TRANSFER produce carry_out = 0.
//  Ports    : a, b, carry_in  - 1-bit operands and carry
//             select [2:0]    - slice opcode (AND/NOT/OR/XOR/ADD/TRANSFER)
//             out, carry_out  - 1-bit result and carry
//  Revision : 1.0  initial release
// ============================================================================
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);

    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (select)
            OP_AND:      out = a & b;
            OP_NOT:      out = ~a;
            OP_OR:       out = a | b;
            OP_XOR:      out = a ^ b;
            OP_ADD: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (a & carry_in) | (b & carry_in);
            end
            OP_TRANSFER: out = a;
            // SUB and TEST are remapped by the sequencer and never reach here.
            default:     out = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_seq
//  Purpose  : Bit-serial sequencer running a WIDTH-bit operation through one
//             time-shared 1-bit ALU slice, LSB first, one bit per clock.
//             IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//  Ports    : clk, reset (async, active high)
//             start/ready          - request handshake (ready high in IDLE)
//             a, b [WIDTH-1:0]     - operands, sampled on accept
//             select [2:0]         - opcode, sampled on accept
//             result [WIDTH-1:0]   - last committed result (TEST never writes)
//             carry_out            - final carry of ADD/SUB, else 0
//             done                 - one-cycle pulse while in DONE
//             zero, overflow       - status flags (ALU_SERIAL_FLAGS_EN only)
//  Config   : `define ALU_SERIAL_FLAGS_EN to add zero/overflow outputs.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef ALU_SERIAL_FLAGS_EN
    output logic             done,
    output logic             zero,
    output logic             overflow
`else
    output logic             done
`endif
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [2:0]         r_op;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;

    logic               w_is_arith;
    logic [2:0]         w_slice_op;
    logic               w_b_eff;
    logic               w_slice_out;
    logic               w_slice_carry;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // SUB runs as ADD of ~b with carry-in 1; TEST runs as AND.
    assign w_is_arith = is_arith(r_op);
    assign w_slice_op = (r_op == OP_SUB)  ? OP_ADD :
                        (r_op == OP_TEST) ? OP_AND : r_op;
    assign w_b_eff    = (r_op == OP_SUB) ? ~r_b_sh[0] : r_b_sh[0];
    assign w_last     = (r_cnt == c_last_bit);
    assign w_res_next = {w_slice_out, r_res_sh[WIDTH-1:1]};

    alu_bit_slice u_slice (
        .a         (r_a_sh[0]),
        .b         (w_b_eff),
        .carry_in  (r_carry),
        .select    (w_slice_op),
        .out       (w_slice_out),
        .carry_out (w_slice_carry)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- outputs decoded from state ----------------
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (r_state)
            IDLE:    ready = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // Results are committed on the edge that enters DONE so they are visible
    // in the same cycle as the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_op        <= OP_AND;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_op     <= select;
                        r_cnt    <= '0;
                        r_carry  <= (select == OP_SUB);
                        r_res_sh <= '0;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_carry  <= w_is_arith ? w_slice_carry : 1'b0;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (r_op != OP_TEST) begin
                            r_result <= w_res_next;
                        end
                        r_carry_out <= w_is_arith ? w_slice_carry : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;

`ifdef ALU_SERIAL_FLAGS_EN
    logic r_zero;
    logic r_overflow;

    // On the last bit r_carry is the carry into the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_zero     <= (w_res_next == '0);
            r_overflow <= w_is_arith ? (r_carry ^ w_slice_carry) : 1'b0;
        end
    end

    assign zero     = r_zero;
    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_serial_seq
//  Purpose  : Self-checking bench for alu_serial_seq (WIDTH=4). Directed
//             vectors push expected results into a queue; a monitor pops and
//             compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_serial_seq;
    import alu_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   select;
    logic [W-1:0] result;
    logic         carry_out;
    logic         done;
`ifdef ALU_SERIAL_FLAGS_EN
    logic         zero;
    logic         overflow;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .select    (select),
        .result    (result),
        .carry_out (carry_out),
`ifdef ALU_SERIAL_FLAGS_EN
        .done      (done),
        .zero      (zero),
        .overflow  (overflow)
`else
        .done      (done)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry_out", 32'(carry_out), 32'(e.c));
`ifdef ALU_SERIAL_FLAGS_EN
                check("zero", 32'(zero), 32'(e.z));
                check("overflow", 32'(overflow), 32'(e.o));
`endif
            end
        end
    end

    // Issue one operation and follow it through to IDLE. With pulse set, a
    // conflicting start is driven mid-RUN; it must be ignored.
    task automatic run_op(input logic [2:0] sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ec, input logic ez, input logic eo,
                          input bit pulse);
        int n;
        exp_t e;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        a      = av;
        b      = bv;
        select = sel;
        start  = 1'b1;
        e.res = er; e.c = ec; e.z = ez; e.o = eo;
        exp_q.push_back(e);
        @(posedge clk);                     // accepting edge E0
        @(negedge clk);
        start = 1'b0;
        check("ready_low_in_run", 32'(ready), 32'd0);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);                 // edge Ek computes bit k-1
            @(negedge clk);
            if (k < W) begin
                check("done_not_early", 32'(done), 32'd0);
                check("ready_low_busy", 32'(ready), 32'd0);
            end
            if (pulse && k == 2) begin
                a      = ~av;
                b      = ~bv;
                select = OP_OR;
                start  = 1'b1;
            end
            if (pulse && k == 3) start = 1'b0;
        end
        check("done_latency", 32'(done), 32'd1);
        check("ready_low_in_done", 32'(ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(ready), 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        select = OP_AND;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        //      op           a     b     result c  z  o  pulse
        run_op(OP_ADD,      4'hB, 4'h6, 4'h1, 1, 0, 0, 1);
        run_op(OP_SUB,      4'h3, 4'h5, 4'hE, 0, 0, 0, 0);
        run_op(OP_SUB,      4'h5, 4'h3, 4'h2, 1, 0, 0, 0);
        run_op(OP_XOR,      4'hA, 4'hF, 4'h5, 0, 0, 0, 0);
        run_op(OP_NOT,      4'h9, 4'h3, 4'h6, 0, 0, 0, 0);
        run_op(OP_TRANSFER, 4'h7, 4'hC, 4'h7, 0, 0, 0, 0);
        run_op(OP_AND,      4'hC, 4'hA, 4'h8, 0, 0, 0, 0);
        run_op(OP_OR,       4'h9, 4'h4, 4'hD, 0, 0, 0, 0);

        // Abort an ADD 0xF+0x1 after bit 2; no done may follow.
        a      = 4'hF;
        b      = 4'h1;
        select = OP_ADD;
        start  = 1'b1;
        @(posedge clk);                     // E0
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);          // bits 0..2
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry", 32'(carry_out), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_pending", 32'(exp_q.size()), 32'd0);

        run_op(OP_ADD,      4'h2, 4'h2, 4'h4, 0, 0, 0, 0);
        // TEST leaves result at 0x4; a AND b = 0 sets zero.
        run_op(OP_TEST,     4'h3, 4'hC, 4'h4, 0, 1, 0, 0);
        run_op(OP_ADD,      4'h8, 4'h8, 4'h0, 1, 1, 1, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
